// File: rtl/rsa_io_pkg.sv
// Shared definitions for the RSA PIO sequencer: FSM states, PIO command/status codes.
package rsa_io_pkg;

  localparam int WORDS_DEF = 4;

  localparam logic [3:0] CMD_IDLE     = 4'd0;
  localparam logic [3:0] CMD_LOAD_MSG = 4'd1;
  localparam logic [3:0] CMD_LOAD_EXP = 4'd2;
  localparam logic [3:0] CMD_LOAD_MOD = 4'd3;
  localparam logic [3:0] CMD_START    = 4'd4;
  localparam logic [3:0] CMD_READ     = 4'd5;

  localparam logic [3:0] ST_READY = 4'd0;
  localparam logic [3:0] ST_ACK   = 4'd1;
  localparam logic [3:0] ST_BUSY  = 4'd2;
  localparam logic [3:0] ST_DONE  = 4'd3;
  localparam logic [3:0] ST_ERROR = 4'd15;

  localparam logic [1:0] OP_MSG = 2'd0;
  localparam logic [1:0] OP_EXP = 2'd1;
  localparam logic [1:0] OP_MOD = 2'd2;

  typedef enum logic [2:0] {
    S_READY, S_LOAD_ACK, S_RUN, S_DONE, S_READ_ACK, S_ERROR
  } state_t;

  function automatic logic [3:0] status_of(state_t s);
    case (s)
      S_READY:    return ST_READY;
      S_LOAD_ACK: return ST_ACK;
      S_RUN:      return ST_BUSY;
      S_DONE:     return ST_DONE;
      S_READ_ACK: return ST_ACK;
      default:    return ST_ERROR;
    endcase
  endfunction

endpackage

// File: rtl/rsa_operand_bank.sv
// Three word-indexed operand registers (msg/exp/mod), each with its own wrapping write index.
module rsa_operand_bank
  import rsa_io_pkg::*;
#(
  parameter int WORDS = WORDS_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic               clr,
  input  logic [1:0]         sel,
  input  logic [31:0]        data,
  output logic [WORDS*32-1:0] msg,
  output logic [WORDS*32-1:0] exp,
  output logic [WORDS*32-1:0] mod
);

  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic [2:0][IW-1:0]             idx;
  logic [2:0][WORDS-1:0][31:0]    regs;

  always_ff @(posedge clk) begin
    if (reset) begin
      idx  <= '0;
      regs <= '0;
    end else if (clr) begin
      idx <= '0;
    end else if (we && sel != 2'd3) begin
      regs[sel][idx[sel]] <= data;
      idx[sel] <= (idx[sel] == IW'(WORDS-1)) ? '0 : idx[sel] + 1'b1;
    end
  end

  assign msg = regs[OP_MSG];
  assign exp = regs[OP_EXP];
  assign mod = regs[OP_MOD];

endmodule

// File: rtl/rsa_io_sequencer.sv
// PIO command sequencer: loads RSA operands word by word, starts the core, returns the result.
module rsa_io_sequencer
  import rsa_io_pkg::*;
#(
  parameter int WORDS = WORDS_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         to_hw_port,
  input  logic [3:0]          to_hw_sig,
  output logic [31:0]         to_sw_port,
  output logic [3:0]          to_sw_sig,
  output logic [WORDS*32-1:0] msg_o,
  output logic [WORDS*32-1:0] exp_o,
  output logic [WORDS*32-1:0] mod_o,
  output logic                core_start,
  input  logic                core_done,
  input  logic [WORDS*32-1:0] core_result
);

  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  state_t                  state, state_nx;
  logic                    sig_seen;
  logic                    cmd_new;
  logic                    ld_we, clr_idx, do_read;
  logic [1:0]              ld_sel;
  logic [IW-1:0]           rd_idx;
  logic [WORDS-1:0][31:0]  result;
  logic                    done_ok;

  // Commands execute only on a 0 -> nonzero transition, so a held command never repeats.
  assign cmd_new = (to_hw_sig != CMD_IDLE) && !sig_seen;
  // The core cannot finish during its own start pulse.
  assign done_ok = core_done && !core_start;

  always_ff @(posedge clk) begin
    if (reset) state <= S_READY;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ld_we    = 1'b0;
    ld_sel   = OP_MSG;
    clr_idx  = 1'b0;
    do_read  = 1'b0;
    case (state)
      S_READY: if (cmd_new) begin
        case (to_hw_sig)
          CMD_LOAD_MSG: begin ld_we = 1'b1; ld_sel = OP_MSG; state_nx = S_LOAD_ACK; end
          CMD_LOAD_EXP: begin ld_we = 1'b1; ld_sel = OP_EXP; state_nx = S_LOAD_ACK; end
          CMD_LOAD_MOD: begin ld_we = 1'b1; ld_sel = OP_MOD; state_nx = S_LOAD_ACK; end
          CMD_START:    state_nx = S_RUN;
          default:      state_nx = S_ERROR;
        endcase
      end
      S_LOAD_ACK: if (to_hw_sig == CMD_IDLE) state_nx = S_READY;
      S_RUN:      if (done_ok) state_nx = S_DONE;
      S_DONE: if (cmd_new) begin
        if (to_hw_sig == CMD_READ) begin
          do_read  = 1'b1;
          state_nx = S_READ_ACK;
        end else begin
          state_nx = S_ERROR;
        end
      end
      S_READ_ACK: if (to_hw_sig == CMD_IDLE) begin
        if (rd_idx == IW'(WORDS-1)) begin
          clr_idx  = 1'b1;
          state_nx = S_READY;
        end else begin
          state_nx = S_DONE;
        end
      end
      S_ERROR: if (to_hw_sig == CMD_IDLE) begin
        clr_idx  = 1'b1;
        state_nx = S_READY;
      end
      default: state_nx = S_READY;
    endcase
  end

  always_comb begin
    to_sw_sig = status_of(state);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sig_seen   <= 1'b0;
      core_start <= 1'b0;
      rd_idx     <= '0;
      result     <= '0;
      to_sw_port <= '0;
    end else begin
      sig_seen   <= (to_hw_sig != CMD_IDLE);
      core_start <= (state == S_READY) && (state_nx == S_RUN);
      if (state == S_RUN && done_ok) result <= core_result;
      if (clr_idx || (state == S_RUN && done_ok))
        rd_idx <= '0;
      else if (state == S_READ_ACK && state_nx == S_DONE)
        rd_idx <= rd_idx + 1'b1;
      if (do_read) to_sw_port <= result[rd_idx];
    end
  end

  rsa_operand_bank #(.WORDS(WORDS)) u_bank (
    .clk   (clk),
    .reset (reset),
    .we    (ld_we),
    .clr   (clr_idx),
    .sel   (ld_sel),
    .data  (to_hw_port),
    .msg   (msg_o),
    .exp   (exp_o),
    .mod   (mod_o)
  );

endmodule

// File: tb/tb_rsa_io_sequencer.sv
// Directed + randomized bench for rsa_io_sequencer against a word-array model of the PIO protocol.
module tb_rsa_io_sequencer;
  import rsa_io_pkg::*;

  localparam int W = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [31:0]       to_hw_port;
  logic [3:0]        to_hw_sig;
  logic [31:0]       to_sw_port;
  logic [3:0]        to_sw_sig;
  logic [W*32-1:0]   msg_o, exp_o, mod_o;
  logic              core_start;
  logic              core_done;
  logic [W*32-1:0]   core_result;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] m_op [3][W];
  int          m_idx [3];
  logic [31:0] m_res [W];

  rsa_io_sequencer #(.WORDS(W)) dut (
    .clk(clk), .reset(reset), .to_hw_port(to_hw_port), .to_hw_sig(to_hw_sig),
    .to_sw_port(to_sw_port), .to_sw_sig(to_sw_sig), .msg_o(msg_o), .exp_o(exp_o),
    .mod_o(mod_o), .core_start(core_start), .core_done(core_done), .core_result(core_result)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W*32-1:0] obs, input logic [W*32-1:0] want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  function automatic logic [W*32-1:0] flat(input int op);
    logic [W*32-1:0] f;
    for (int i = 0; i < W; i++) f[i*32 +: 32] = m_op[op][i];
    return f;
  endfunction

  task automatic model_reset();
    for (int o = 0; o < 3; o++) begin
      m_idx[o] = 0;
      for (int i = 0; i < W; i++) m_op[o][i] = '0;
    end
    for (int i = 0; i < W; i++) m_res[i] = '0;
  endtask

  task automatic model_clear_idx();
    for (int o = 0; o < 3; o++) m_idx[o] = 0;
  endtask

  task automatic chk_ops(input string tag);
    chk({tag, "_msg"}, msg_o, flat(0));
    chk({tag, "_exp"}, exp_o, flat(1));
    chk({tag, "_mod"}, mod_o, flat(2));
  endtask

  task automatic load(input int op, input logic [31:0] d);
    to_hw_port = d;
    tick();
    to_hw_sig = 4'(1 + op);
    tick();
    chk("load_ack", to_sw_sig, ST_ACK);
    m_op[op][m_idx[op]] = d;
    m_idx[op] = (m_idx[op] + 1) % W;
    to_hw_sig = CMD_IDLE;
    tick();
    chk("load_release", to_sw_sig, ST_READY);
  endtask

  task automatic run_op(input logic [W*32-1:0] res, input int delay);
    to_hw_sig = CMD_START;
    tick();
    chk("start_pulse", core_start, 1);
    chk("start_busy", to_sw_sig, ST_BUSY);
    to_hw_sig = CMD_IDLE;
    tick();
    chk("start_pulse_end", core_start, 0);
    repeat (delay) tick();
    chk("busy_wait", to_sw_sig, ST_BUSY);
    core_done = 1'b1;
    core_result = res;
    tick();
    core_done = 1'b0;
    core_result = {$urandom, $urandom, $urandom, $urandom};
    chk("done_status", to_sw_sig, ST_DONE);
    for (int i = 0; i < W; i++) m_res[i] = res[i*32 +: 32];
  endtask

  task automatic read_all();
    for (int i = 0; i < W; i++) begin
      to_hw_sig = CMD_READ;
      tick();
      chk("read_ack", to_sw_sig, ST_ACK);
      chk("read_word", to_sw_port, m_res[i]);
      to_hw_sig = CMD_IDLE;
      tick();
      chk("read_release", to_sw_sig, (i == W-1) ? ST_READY : ST_DONE);
      chk("read_hold", to_sw_port, m_res[i]);
    end
    model_clear_idx();
  endtask

  task automatic error_cmd(input logic [3:0] c);
    to_hw_sig = c;
    tick();
    chk("err_status", to_sw_sig, ST_ERROR);
    to_hw_sig = CMD_IDLE;
    tick();
    chk("err_release", to_sw_sig, ST_READY);
    model_clear_idx();
  endtask

  initial begin
    logic [31:0] d0, d1;
    reset = 1'b1; to_hw_port = '0; to_hw_sig = CMD_IDLE;
    core_done = 1'b0; core_result = '0;
    model_reset();
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_status", to_sw_sig, ST_READY);
    chk("rst_port", to_sw_port, 0);
    chk("rst_start", core_start, 0);
    chk_ops("rst");

    // Directed MSG load
    load(0, 32'h11111111); load(0, 32'h22222222);
    load(0, 32'h33333333); load(0, 32'h44444444);
    chk("msg_directed", msg_o, 128'h44444444_33333333_22222222_11111111);

    // Directed run and readback
    run_op(128'hDEADBEEF_00000000_00000000_CAFEF00D, 3);
    read_all();

    // Held LOAD_EXP writes exactly one word
    d0 = $urandom; d1 = $urandom;
    to_hw_port = d0;
    tick();
    to_hw_sig = CMD_LOAD_EXP;
    repeat (20) tick();
    chk("hold_ack", to_sw_sig, ST_ACK);
    to_hw_sig = CMD_IDLE;
    tick();
    m_op[1][m_idx[1]] = d0; m_idx[1] = (m_idx[1] + 1) % W;
    load(1, d1);
    chk_ops("hold");

    // Illegal command and READ in READY
    error_cmd(4'd9);
    chk_ops("err9");
    error_cmd(CMD_READ);
    chk_ops("err_read");

    // Randomized sessions
    for (int r = 0; r < 4; r++) begin
      int n;
      n = $urandom_range(1, 9);
      for (int k = 0; k < n; k++) load($urandom_range(0, 2), $urandom);
      chk_ops("rand_load");
      run_op({$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 6));
      if (r == 1) error_cmd(CMD_LOAD_MOD);
      else read_all();
      chk_ops("rand_after");
    end

    // Reset during RUN, then stale core_done
    to_hw_sig = CMD_START;
    tick();
    chk("rst_run_busy", to_sw_sig, ST_BUSY);
    to_hw_sig = CMD_IDLE;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    chk("rst_run_status", to_sw_sig, ST_READY);
    chk("rst_run_start", core_start, 0);
    core_done = 1'b1; core_result = {$urandom, $urandom, $urandom, $urandom};
    tick();
    core_done = 1'b0;
    tick();
    chk("stale_done", to_sw_sig, ST_READY);
    chk("stale_port", to_sw_port, 0);
    chk_ops("stale");
    error_cmd(CMD_READ);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
